// File: rtl/lc3b_decode_stage_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | lc3b_decode_stage_pkg                                                      |
// | Shared LC-3b types: opcodes, ALU operations and the decoded control word.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package lc3b_decode_stage_pkg;

  typedef enum logic [3:0] {
    op_br   = 4'b0000,
    op_add  = 4'b0001,
    op_ldb  = 4'b0010,
    op_stb  = 4'b0011,
    op_jsr  = 4'b0100,
    op_and  = 4'b0101,
    op_ldr  = 4'b0110,
    op_str  = 4'b0111,
    op_ops  = 4'b1000,
    op_not  = 4'b1001,
    op_ldi  = 4'b1010,
    op_sti  = 4'b1011,
    op_jmp  = 4'b1100,
    op_shf  = 4'b1101,
    op_lea  = 4'b1110,
    op_trap = 4'b1111
  } lc3b_opcode;

  typedef enum logic [3:0] {
    alu_add  = 4'd0,
    alu_and  = 4'd1,
    alu_not  = 4'd2,
    alu_pass = 4'd3,
    alu_sll  = 4'd4,
    alu_srl  = 4'd5,
    alu_sra  = 4'd6,
    alu_or   = 4'd7,
    alu_nor  = 4'd8,
    alu_xor  = 4'd9,
    alu_xnor = 4'd10,
    alu_sub  = 4'd11,
    alu_nand = 4'd12
  } lc3b_aluop;

  // regfilemux_sel: 0 alu, 1 memory word, 2 memory byte, 3 pc (link), 4 address
  typedef struct packed {
    lc3b_opcode opcode;
    lc3b_aluop  aluop;
    logic       load_regfile;
    logic       load_cc;
    logic       read_memory;
    logic       write_memory;
    logic       branch;
    logic       uses_sr1;
    logic       uses_sr2;
    logic       uses_dest;
    logic [1:0] memory_wmask;
    logic       sr2mux_sel;
    logic [2:0] regfilemux_sel;
    logic [3:0] imm4;
  } lc3b_control;

  localparam lc3b_control CTRL_NOP = '0;
  localparam logic [2:0]  LINK_REG = 3'd7;

  function automatic logic is_store(input lc3b_opcode op);
    return (op == op_str) || (op == op_stb) || (op == op_sti);
  endfunction

endpackage
`default_nettype wire

// File: rtl/lc3b_decode_stage_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | lc3b_decoder                                                               |
// | Combinational LC-3b instruction decoder: control word and specifiers.      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module lc3b_decoder
  import lc3b_decode_stage_pkg::*;
(
  input  logic [15:0] ir,
  output lc3b_control ctrl,
  output logic [2:0]  sr1,
  output logic [2:0]  sr2,
  output logic [2:0]  dest
);

  lc3b_opcode w_op;

  assign w_op = lc3b_opcode'(ir[15:12]);
  assign sr1  = ir[8:6];
  assign sr2  = is_store(w_op) ? ir[11:9] : ir[2:0];
  assign dest = ((w_op == op_jsr) || (w_op == op_trap)) ? LINK_REG : ir[11:9];

  always_comb begin
    ctrl        = CTRL_NOP;
    ctrl.opcode = w_op;
    ctrl.aluop  = alu_add;
    case (w_op)
      op_add, op_and: begin
        {ctrl.load_regfile, ctrl.load_cc, ctrl.uses_dest, ctrl.uses_sr1} = 4'b1111;
        ctrl.uses_sr2   = ~ir[5];
        ctrl.sr2mux_sel = ir[5];
        ctrl.aluop      = (w_op == op_add) ? alu_add : alu_and;
      end
      op_not: begin
        {ctrl.load_regfile, ctrl.load_cc, ctrl.uses_dest, ctrl.uses_sr1} = 4'b1111;
        ctrl.aluop = alu_not;
      end
      op_ops: begin
        {ctrl.load_regfile, ctrl.load_cc, ctrl.uses_dest, ctrl.uses_sr1} = 4'b1111;
        ctrl.uses_sr2   = ~ir[5];
        ctrl.sr2mux_sel = ir[5];
        case (ir[2:0])
          3'b000:  ctrl.aluop = alu_or;
          3'b001:  ctrl.aluop = alu_nor;
          3'b010:  ctrl.aluop = alu_xor;
          3'b011:  ctrl.aluop = alu_xnor;
          3'b100:  ctrl.aluop = alu_sub;
          3'b101:  ctrl.aluop = alu_nand;
          // Reserved sub-ops must not disturb the register file.
          default: begin
            ctrl.aluop        = alu_pass;
            ctrl.load_regfile = 1'b0;
          end
        endcase
      end
      op_shf: begin
        {ctrl.load_regfile, ctrl.load_cc, ctrl.uses_dest, ctrl.uses_sr1} = 4'b1111;
        ctrl.imm4 = ir[3:0];
        case (ir[5:4])
          2'b01:   ctrl.aluop = alu_srl;
          2'b11:   ctrl.aluop = alu_sra;
          default: ctrl.aluop = alu_sll;
        endcase
      end
      op_ldr, op_ldi, op_ldb: begin
        {ctrl.load_regfile, ctrl.load_cc, ctrl.uses_dest, ctrl.uses_sr1} = 4'b1111;
        ctrl.read_memory    = 1'b1;
        ctrl.regfilemux_sel = (w_op == op_ldb) ? 3'd2 : 3'd1;
      end
      op_lea: begin
        {ctrl.load_regfile, ctrl.load_cc, ctrl.uses_dest} = 3'b111;
        ctrl.regfilemux_sel = 3'd4;
      end
      // STB byte lanes depend on the address LSB, which is only known in EX.
      op_str, op_sti, op_stb: begin
        {ctrl.write_memory, ctrl.uses_sr1, ctrl.uses_sr2} = 3'b111;
        ctrl.memory_wmask = (w_op == op_stb) ? 2'b00 : 2'b11;
      end
      op_br: ctrl.branch = 1'b1;
      op_jmp: begin
        ctrl.branch   = 1'b1;
        ctrl.uses_sr1 = 1'b1;
      end
      op_jsr: begin
        {ctrl.branch, ctrl.load_regfile, ctrl.uses_dest} = 3'b111;
        ctrl.uses_sr1       = ~ir[11];
        ctrl.regfilemux_sel = 3'd3;
      end
      op_trap: begin
        {ctrl.branch, ctrl.load_regfile, ctrl.uses_dest, ctrl.read_memory} = 4'b1111;
        ctrl.regfilemux_sel = 3'd3;
      end
      default: ctrl = CTRL_NOP;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/lc3b_decode_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | lc3b_decode_stage                                                          |
// | LC-3b ID stage: decode, ID/EX register, handshake and load-use bubble.     |
// | Optional LC3B_DECODE_PERF_EN adds saturating stall/flush counters.         |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module lc3b_decode_stage
  import lc3b_decode_stage_pkg::*;
#(
  parameter logic [15:0] NOP_IR = 16'h0000
)
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_valid,
  input  logic [15:0] if_ir,
  input  logic [15:0] if_pc,
  output logic        if_ready,
  input  logic        flush,
  input  logic        ex_valid,
  input  logic        ex_ctrl_read_memory,
  input  logic [2:0]  ex_dest,
  input  logic        ex_uses_dest,
  input  logic        ex_ready,
  output logic        id_valid,
  output lc3b_control id_ctrl,
  output logic [15:0] id_ir,
  output logic [15:0] id_pc,
  output logic [2:0]  id_sr1,
  output logic [2:0]  id_sr2,
  output logic [2:0]  id_dest
`ifdef LC3B_DECODE_PERF_EN
  ,
  output logic [15:0] perf_stall_cnt,
  output logic [15:0] perf_flush_cnt
`endif
);

  lc3b_control w_dec_ctrl;
  logic [2:0]  w_dec_sr1;
  logic [2:0]  w_dec_sr2;
  logic [2:0]  w_dec_dest;
  logic        w_advance;
  logic        w_hazard;

  lc3b_decoder u_decoder (
    .ir   (if_ir),
    .ctrl (w_dec_ctrl),
    .sr1  (w_dec_sr1),
    .sr2  (w_dec_sr2),
    .dest (w_dec_dest)
  );

  assign w_advance = ~id_valid | ex_ready;
  assign w_hazard  = if_valid & ex_valid & ex_ctrl_read_memory & ex_uses_dest &
                     ((w_dec_ctrl.uses_sr1 & (w_dec_sr1 == ex_dest)) |
                      (w_dec_ctrl.uses_sr2 & (w_dec_sr2 == ex_dest)));
  assign if_ready  = w_advance & ~w_hazard & ~flush;

  // Every path that drops id_valid also zeroes the control word and IR.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_valid <= 1'b0;
      id_ctrl  <= CTRL_NOP;
      id_ir    <= NOP_IR;
      id_pc    <= 16'h0000;
      id_sr1   <= 3'd0;
      id_sr2   <= 3'd0;
      id_dest  <= 3'd0;
    end else if (flush || (w_advance && (w_hazard || !if_valid))) begin
      id_valid <= 1'b0;
      id_ctrl  <= CTRL_NOP;
      id_ir    <= NOP_IR;
    end else if (w_advance) begin
      id_valid <= 1'b1;
      id_ctrl  <= w_dec_ctrl;
      id_ir    <= if_ir;
      id_pc    <= if_pc;
      id_sr1   <= w_dec_sr1;
      id_sr2   <= w_dec_sr2;
      id_dest  <= w_dec_dest;
    end
  end

`ifdef LC3B_DECODE_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_stall_cnt <= 16'h0000;
      perf_flush_cnt <= 16'h0000;
    end else begin
      if (w_advance && w_hazard && !flush && (perf_stall_cnt != 16'hFFFF))
        perf_stall_cnt <= perf_stall_cnt + 16'd1;
      if (flush && (perf_flush_cnt != 16'hFFFF))
        perf_flush_cnt <= perf_flush_cnt + 16'd1;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_lc3b_decode_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_lc3b_decode_stage                                                       |
// | Self-checking bench: directed scenarios plus randomized reference model.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_lc3b_decode_stage;
  import lc3b_decode_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_valid, flush, ex_valid, ex_ctrl_read_memory, ex_uses_dest, ex_ready;
  logic [15:0] if_ir, if_pc;
  logic [2:0]  ex_dest;
  logic        if_ready, id_valid;
  lc3b_control id_ctrl;
  logic [15:0] id_ir, id_pc;
  logic [2:0]  id_sr1, id_sr2, id_dest;
`ifdef LC3B_DECODE_PERF_EN
  logic [15:0] perf_stall_cnt, perf_flush_cnt;
`endif

  int checks = 0;
  int failures = 0;

  lc3b_decode_stage dut (
    .clk(clk), .rst_n(rst_n), .if_valid(if_valid), .if_ir(if_ir), .if_pc(if_pc),
    .if_ready(if_ready), .flush(flush), .ex_valid(ex_valid),
    .ex_ctrl_read_memory(ex_ctrl_read_memory), .ex_dest(ex_dest),
    .ex_uses_dest(ex_uses_dest), .ex_ready(ex_ready), .id_valid(id_valid),
    .id_ctrl(id_ctrl), .id_ir(id_ir), .id_pc(id_pc), .id_sr1(id_sr1),
    .id_sr2(id_sr2), .id_dest(id_dest)
`ifdef LC3B_DECODE_PERF_EN
    , .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Spec-visible decode fields; aluop only matters for ALU opcodes.
  typedef struct packed {
    logic [3:0] opcode;
    logic [3:0] aluop;
    logic lr, lcc, rm, wm, br, u1, u2, ud;
    logic [1:0] wmask;
  } key_t;

  function automatic logic is_alu_op(input logic [3:0] op);
    return op inside {op_add, op_and, op_not, op_ops, op_shf};
  endfunction

  function automatic key_t key_of(input lc3b_control c, input logic [15:0] ir);
    key_t k;
    k.opcode = c.opcode;
    k.aluop  = is_alu_op(ir[15:12]) ? c.aluop : 4'd0;
    k.lr = c.load_regfile; k.lcc = c.load_cc; k.rm = c.read_memory;
    k.wm = c.write_memory; k.br = c.branch; k.u1 = c.uses_sr1;
    k.u2 = c.uses_sr2; k.ud = c.uses_dest; k.wmask = c.memory_wmask;
    return k;
  endfunction

  function automatic key_t model_key(input logic [15:0] ir);
    key_t k;
    logic [3:0] op;
    op = ir[15:12];
    k = '0;
    k.opcode = op;
    k.lr  = op inside {op_add, op_and, op_not, op_ops, op_shf, op_ldr, op_ldb, op_ldi, op_lea, op_jsr, op_trap};
    k.ud  = k.lr;
    k.lcc = op inside {op_add, op_and, op_not, op_ops, op_shf, op_ldr, op_ldb, op_ldi, op_lea};
    k.rm  = op inside {op_ldr, op_ldb, op_ldi, op_trap};
    k.wm  = op inside {op_str, op_stb, op_sti};
    k.br  = op inside {op_br, op_jmp, op_jsr, op_trap};
    k.u1  = (op inside {op_add, op_and, op_not, op_ops, op_shf, op_ldr, op_ldb, op_ldi,
                        op_str, op_stb, op_sti, op_jmp}) || (op == op_jsr && !ir[11]);
    k.u2  = k.wm || ((op inside {op_add, op_and, op_ops}) && !ir[5]);
    k.wmask = (op == op_str || op == op_sti) ? 2'b11 : 2'b00;
    if (op == op_add) k.aluop = alu_add;
    if (op == op_and) k.aluop = alu_and;
    if (op == op_not) k.aluop = alu_not;
    if (op == op_shf) k.aluop = (ir[5:4] == 2'b01) ? alu_srl : (ir[5:4] == 2'b11) ? alu_sra : alu_sll;
    if (op == op_ops) begin
      case (ir[2:0])
        3'd0: k.aluop = alu_or;
        3'd1: k.aluop = alu_nor;
        3'd2: k.aluop = alu_xor;
        3'd3: k.aluop = alu_xnor;
        3'd4: k.aluop = alu_sub;
        3'd5: k.aluop = alu_nand;
        default: begin k.aluop = alu_pass; k.lr = 1'b0; end
      endcase
    end
    return k;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    if_valid = 0; if_ir = 16'h0; if_pc = 16'h0; flush = 0; ex_valid = 0;
    ex_ctrl_read_memory = 0; ex_dest = 3'd0; ex_uses_dest = 0; ex_ready = 1;
  endtask

  task automatic test_reset;
    rst_n = 0;
    idle_inputs();
    repeat (2) tick();
    checks++; if (id_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", id_valid); end
    checks++; if (id_ir !== 16'h0000) begin failures++; $display("FAIL reset_ir got=%h exp=0000", id_ir); end
    checks++; if (id_ctrl !== CTRL_NOP) begin failures++; $display("FAIL reset_ctrl got=%h exp=0", id_ctrl); end
    checks++; if ({id_pc, id_sr1, id_sr2, id_dest} !== 25'd0) begin failures++; $display("FAIL reset_pc_spec got=%h/%0d/%0d/%0d exp=0", id_pc, id_sr1, id_sr2, id_dest); end
    checks++; if (if_ready !== 1'b1) begin failures++; $display("FAIL reset_if_ready got=%b exp=1", if_ready); end
    rst_n = 1;
    tick();
  endtask

  task automatic test_add;
    if_valid = 1; if_ir = 16'h1283; if_pc = 16'h3002; ex_ready = 1;
    #1;
    checks++; if (if_ready !== 1'b1) begin failures++; $display("FAIL add_if_ready got=%b exp=1", if_ready); end
    tick();
    if_valid = 0;
    checks++; if (id_valid !== 1'b1) begin failures++; $display("FAIL add_valid got=%b exp=1", id_valid); end
    checks++; if (id_ctrl.aluop !== alu_add || id_ctrl.load_regfile !== 1'b1 || id_ctrl.load_cc !== 1'b1)
      begin failures++; $display("FAIL add_ctrl got=%h aluop/lr/lcc=%0d/%b/%b exp=add/1/1", id_ctrl, id_ctrl.aluop, id_ctrl.load_regfile, id_ctrl.load_cc); end
    checks++; if ({id_sr1, id_sr2, id_dest} !== {3'd2, 3'd3, 3'd1}) begin failures++; $display("FAIL add_spec got=%0d/%0d/%0d exp=2/3/1", id_sr1, id_sr2, id_dest); end
    checks++; if (id_ir !== 16'h1283 || id_pc !== 16'h3002) begin failures++; $display("FAIL add_irpc got=%h/%h exp=1283/3002", id_ir, id_pc); end
    tick();
    checks++; if (id_valid !== 1'b0 || id_ctrl !== CTRL_NOP || id_ir !== 16'h0000)
      begin failures++; $display("FAIL add_drain got=%b/%h/%h exp=0/0/0000", id_valid, id_ctrl, id_ir); end
  endtask

  task automatic test_load_use;
    ex_valid = 1; ex_ctrl_read_memory = 1; ex_uses_dest = 1; ex_dest = 3'd2; ex_ready = 1;
    if_valid = 1; if_ir = 16'h12A1; if_pc = 16'h3010;
    #1;
    checks++; if (if_ready !== 1'b0) begin failures++; $display("FAIL lu_if_ready got=%b exp=0", if_ready); end
    tick();
    checks++; if (id_valid !== 1'b0 || id_ctrl !== CTRL_NOP) begin failures++; $display("FAIL lu_bubble got=%b/%h exp=0/0", id_valid, id_ctrl); end
    ex_valid = 0;
    #1;
    checks++; if (if_ready !== 1'b1) begin failures++; $display("FAIL lu_release got=%b exp=1", if_ready); end
    tick();
    checks++; if (id_valid !== 1'b1 || id_ir !== 16'h12A1) begin failures++; $display("FAIL lu_load got=%b/%h exp=1/12a1", id_valid, id_ir); end
    idle_inputs();
    tick();
  endtask

  task automatic test_backpressure;
    if_valid = 1; if_ir = 16'h5A42; if_pc = 16'h3020; ex_ready = 1;
    tick();
    ex_ready = 0; if_ir = 16'h9A7F; if_pc = 16'h3022;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (if_ready !== 1'b0) begin failures++; $display("FAIL bp_if_ready cyc=%0d got=%b exp=0", i, if_ready); end
      tick();
      checks++; if (id_valid !== 1'b1 || id_ir !== 16'h5A42 || id_pc !== 16'h3020 || id_ctrl.aluop !== alu_and)
        begin failures++; $display("FAIL bp_hold cyc=%0d got=%b/%h/%h exp=1/5a42/3020", i, id_valid, id_ir, id_pc); end
    end
    ex_ready = 1;
    #1;
    checks++; if (if_ready !== 1'b1) begin failures++; $display("FAIL bp_release got=%b exp=1", if_ready); end
    tick();
    checks++; if (id_ir !== 16'h9A7F || id_ctrl.aluop !== alu_not || id_dest !== 3'd5)
      begin failures++; $display("FAIL bp_next got=%h/%0d/%0d exp=9a7f/not/5", id_ir, id_ctrl.aluop, id_dest); end
    idle_inputs();
    tick();
  endtask

  task automatic test_flush;
    ex_valid = 1; ex_ctrl_read_memory = 1; ex_uses_dest = 1; ex_dest = 3'd2;
    if_valid = 1; if_ir = 16'h12A1; flush = 1;
    #1;
    checks++; if (if_ready !== 1'b0) begin failures++; $display("FAIL fl_hz_ready got=%b exp=0", if_ready); end
    tick();
    checks++; if (id_valid !== 1'b0) begin failures++; $display("FAIL fl_hz_valid got=%b exp=0", id_valid); end
    flush = 0; ex_valid = 0;
    tick();
    checks++; if (id_valid !== 1'b1 || id_ir !== 16'h12A1) begin failures++; $display("FAIL fl_refetch got=%b/%h exp=1/12a1", id_valid, id_ir); end
    ex_ready = 0; flush = 1; if_ir = 16'h1283;
    #1;
    checks++; if (if_ready !== 1'b0) begin failures++; $display("FAIL fl_st_ready got=%b exp=0", if_ready); end
    tick();
    checks++; if (id_valid !== 1'b0 || id_ir !== 16'h0000 || id_ctrl !== CTRL_NOP)
      begin failures++; $display("FAIL fl_st_clear got=%b/%h/%h exp=0/0000/0", id_valid, id_ir, id_ctrl); end
    idle_inputs();
    tick();
  endtask

  task automatic test_back_to_back;
    if_valid = 1; if_ir = 16'h4805; if_pc = 16'h3040;
    tick();
    if_ir = 16'h7940; if_pc = 16'h3042;
    checks++; if (id_dest !== 3'd7 || id_ctrl.branch !== 1'b1 || id_ctrl.uses_sr1 !== 1'b0 || id_ctrl.load_regfile !== 1'b1)
      begin failures++; $display("FAIL jsr got=dest%0d br%b u1%b lr%b exp=7/1/0/1", id_dest, id_ctrl.branch, id_ctrl.uses_sr1, id_ctrl.load_regfile); end
    tick();
    if_valid = 0;
    checks++; if (id_sr1 !== 3'd5 || id_sr2 !== 3'd4 || id_ctrl.write_memory !== 1'b1 || id_ctrl.uses_dest !== 1'b0 || id_ctrl.memory_wmask !== 2'b11)
      begin failures++; $display("FAIL str got=sr1 %0d sr2 %0d wm%b ud%b mask%b exp=5/4/1/0/11", id_sr1, id_sr2, id_ctrl.write_memory, id_ctrl.uses_dest, id_ctrl.memory_wmask); end
    tick();
  endtask

  task automatic test_async_reset;
    if_valid = 1; if_ir = 16'h1283;
    tick();
    #2;
    rst_n = 0;
    #1;
    checks++; if (id_valid !== 1'b0 || id_ir !== 16'h0000 || id_ctrl !== CTRL_NOP)
      begin failures++; $display("FAIL areset got=%b/%h/%h exp=0/0000/0", id_valid, id_ir, id_ctrl); end
    checks++; if (if_ready !== 1'b1) begin failures++; $display("FAIL areset_ready got=%b exp=1", if_ready); end
    #1;
    rst_n = 1;
    idle_inputs();
    tick();
  endtask

  task automatic test_random;
    logic mv;
    logic [15:0] mir, mpc;
    logic [2:0] ms1, ms2, md;
    key_t mk, k;
    logic [2:0] s1, s2, d;
    logic hz, adv;
    int errs_before;
    errs_before = failures;
    rst_n = 0; #1; rst_n = 1;
    mv = 0; mir = 16'h0; mpc = 16'h0; mk = '0; ms1 = 0; ms2 = 0; md = 0;
    for (int n = 0; n < 400; n++) begin
      if_valid = ($urandom_range(0, 3) != 0);
      if_ir = 16'($urandom);
      if_pc = 16'($urandom);
      flush = ($urandom_range(0, 9) == 0);
      ex_valid = 1'($urandom_range(0, 1));
      ex_ctrl_read_memory = 1'($urandom_range(0, 1));
      ex_uses_dest = 1'($urandom_range(0, 1));
      ex_dest = 3'($urandom_range(0, 7));
      ex_ready = ($urandom_range(0, 9) < 7);
      k = model_key(if_ir);
      s1 = if_ir[8:6];
      s2 = (k.wm) ? if_ir[11:9] : if_ir[2:0];
      d = (if_ir[15:12] == op_jsr || if_ir[15:12] == op_trap) ? 3'd7 : if_ir[11:9];
      hz = if_valid && ex_valid && ex_ctrl_read_memory && ex_uses_dest &&
           ((k.u1 && s1 == ex_dest) || (k.u2 && s2 == ex_dest));
      adv = !mv || ex_ready;
      #1;
      checks++; if (if_ready !== (adv && !hz && !flush))
        begin failures++; $display("FAIL rnd_if_ready n=%0d ir=%h got=%b exp=%b", n, if_ir, if_ready, adv && !hz && !flush); end
      if (flush || (adv && (hz || !if_valid))) mv = 0;
      else if (adv) begin
        mv = 1; mir = if_ir; mpc = if_pc; mk = k; ms1 = s1; ms2 = s2; md = d;
      end
      tick();
      checks++; if (id_valid !== mv) begin failures++; $display("FAIL rnd_valid n=%0d got=%b exp=%b", n, id_valid, mv); end
      if (mv) begin
        checks++; if (key_of(id_ctrl, mir) !== mk || id_ir !== mir || id_pc !== mpc || {id_sr1, id_sr2, id_dest} !== {ms1, ms2, md})
          begin failures++; $display("FAIL rnd_decode n=%0d ir=%h got=%h/%0d%0d%0d exp=%h/%0d%0d%0d", n, mir, key_of(id_ctrl, mir), id_sr1, id_sr2, id_dest, mk, ms1, ms2, md); end
      end else begin
        checks++; if (id_ctrl !== CTRL_NOP || id_ir !== 16'h0000)
          begin failures++; $display("FAIL rnd_bubble n=%0d got=%h/%h exp=0/0000", n, id_ctrl, id_ir); end
      end
      if (failures - errs_before > 10) break;
    end
    idle_inputs();
    tick();
  endtask

  initial begin
    test_reset();
    test_add();
    test_load_use();
    test_backpressure();
    test_flush();
    test_back_to_back();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
